fnd_scan: RTL and testbench
===========================

// Module: fnd_scan
// PURPOSE
//  Time-multiplexed N-digit 7-segment (FND) driver, successor to the static 2-digit decoder.
//  Latches packed BCD/hex digits, then scans one digit per tick onto shared active-low
//  segment lines (7'b gfedcba) with an active-low one-hot digit select.
//  Adds hex decode, leading-zero blanking, per-digit blank/blink/dp and tear-free frame updates.
//  Sits between the board-level value/counter logic and the FND pins.
// PARAMETERS
//  NUM_DIGITS   4      number of digits scanned (>=2)
//  SCAN_DIV     50000  clk cycles per digit slot (>=2)
//  HEX_MODE     1      1: codes 10-15 show A,b,C,d,E,F; 0: codes 10-15 show blank
//  BLINK_FRAMES 64     full frames per blink half-period (>=1)
// PORTS
//  clk        in   1              system clock
//  rst        in   1              asynchronous reset, active-high
//  load       in   1              capture digits/blank/blink/dp/lz_en into staging regs
//  digits     in   4*NUM_DIGITS   digit i = digits[4i+3:4i]; digit 0 = rightmost
//  blank      in   NUM_DIGITS     1 = digit i forced dark
//  blink      in   NUM_DIGITS     1 = digit i dark during blink-off phase
//  dp         in   NUM_DIGITS     1 = decimal point lit on digit i
//  lz_en      in   1              1 = suppress leading zeros
//  seg_n      out  7              segments gfedcba, active-low
//  dp_n       out  1              decimal point, active-low
//  dig_n      out  NUM_DIGITS     digit select, active-low one-hot
//  frame_done out  1              1-cycle pulse after last digit of a frame is driven
// BEHAVIOUR
//  Reset (async, any time): seg_n=7'h7F, dp_n=1, dig_n=all 1, frame_done=0; prescaler, idx,
//   blink counter, blink phase, staging and display regs = 0. Reset mid-frame aborts the scan.
//  Prescaler: counts 0..SCAN_DIV-1, wraps; tick = (count==SCAN_DIV-1). First tick at clk
//   edge SCAN_DIV after reset release.
//  On tick: outputs register the view of digit idx (visible next cycle), then
//   idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1. dig_n = ~(1<<idx); exactly one bit low after 1st tick.
//  Frame end = tick with idx==NUM_DIGITS-1: display regs <= staging regs; frame_done=1
//   next cycle only; blink counter increments, wraps at BLINK_FRAMES-1 and toggles blink phase.
//  load: staging regs capture inputs on that edge; display never changes mid-frame.
//   load coincident with frame end: new inputs go to staging only; old staging goes to display.
//  Decode: 0-9 = 40,79,24,30,19,12,02,78,00,10 (hex, 7-bit); HEX_MODE=1: A=08,b=03,C=46,
//   d=21,E=06,F=0E; HEX_MODE=0: 10-15 -> 7F.
//  Leading zeros (lz_en=1): digit i>0 dark if it and all higher digits are 0; digit 0 never suppressed.
//  Dark digit (blank, blink&phase, or LZ suppression): seg_n=7F, dp_n=1, dig_n still selects it.
//  Priority: blank > blink > LZ > decode. dp ignored on dark digits.
// TESTING
//  SCAN_DIV=4,NUM_DIGITS=4: reset, load digits=16'h1234 -> dig_n cycles E,D,B,7 every 4 clk; seg_n 19,30,24,79.
//  Load 16'h5678 mid-frame -> remaining digits of frame still show 1234; next frame shows 5678.
//  HEX_MODE=1 digits=16'hABCD -> 21,46,03,08; HEX_MODE=0 same -> all 7F.
//  lz_en=1 digits=16'h0050 -> dig3,dig2 dark, dig1=12, dig0=40; digits=0 -> only dig0 shows 40.
//  BLINK_FRAMES=2, blink=4'b0001 -> dig0 lit 2 frames, dark 2 frames; others always lit; dp=0001 -> dp_n=0 only on lit dig0.
//  Assert rst mid-scan -> outputs return to reset values immediately; first tick SCAN_DIV cycles after release shows digit 0.

Source files
------------

// File: rtl/fnd_scan.sv
// Time-multiplexed N-digit 7-segment driver: staged digit capture, frame-aligned display
// update, hex/decimal decode, leading-zero blanking and per-digit blank/blink/dp.
module fnd_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int HEX_MODE     = 1,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lz_en,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   dig_n,
  output logic                    frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0:    decode = 7'h40;
      4'h1:    decode = 7'h79;
      4'h2:    decode = 7'h24;
      4'h3:    decode = 7'h30;
      4'h4:    decode = 7'h19;
      4'h5:    decode = 7'h12;
      4'h6:    decode = 7'h02;
      4'h7:    decode = 7'h78;
      4'h8:    decode = 7'h00;
      4'h9:    decode = 7'h10;
      4'hA:    decode = (HEX_MODE != 0) ? 7'h08 : 7'h7F;
      4'hB:    decode = (HEX_MODE != 0) ? 7'h03 : 7'h7F;
      4'hC:    decode = (HEX_MODE != 0) ? 7'h46 : 7'h7F;
      4'hD:    decode = (HEX_MODE != 0) ? 7'h21 : 7'h7F;
      4'hE:    decode = (HEX_MODE != 0) ? 7'h06 : 7'h7F;
      4'hF:    decode = (HEX_MODE != 0) ? 7'h0E : 7'h7F;
      default: decode = 7'h7F;
    endcase
  endfunction

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BW-1:0]           blk_q, blk_d;
  logic                    phase_q, phase_d;
  logic [4*NUM_DIGITS-1:0] stg_dig_q, stg_dig_d, disp_dig_q, disp_dig_d;
  logic [NUM_DIGITS-1:0]   stg_blank_q, stg_blank_d, disp_blank_q, disp_blank_d;
  logic [NUM_DIGITS-1:0]   stg_blink_q, stg_blink_d, disp_blink_q, disp_blink_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, disp_dp_q, disp_dp_d;
  logic                    stg_lz_q, stg_lz_d, disp_lz_q, disp_lz_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dpn_q, dpn_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    fd_q, fd_d;

  logic                    tick_s, frame_end_s, dark_s, hi_zero_s;
  logic [3:0]              cur_val_s;
  logic [NUM_DIGITS-1:0]   lz_dark_s;

  assign tick_s      = (cnt_q == CNT_LAST);
  assign frame_end_s = tick_s && (idx_q == IDX_LAST);

  // Leading-zero mask over the display regs, then the dark decision for the digit in view.
  always_comb begin
    hi_zero_s = 1'b1;
    lz_dark_s = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hi_zero_s    = hi_zero_s & (disp_dig_q[4*i +: 4] == 4'h0);
      lz_dark_s[i] = disp_lz_q & hi_zero_s & (i != 0);
    end
    cur_val_s = disp_dig_q[4*idx_q +: 4];
    dark_s    = disp_blank_q[idx_q] | (disp_blink_q[idx_q] & phase_q) | lz_dark_s[idx_q];
  end

  // Next-state for scan position, prescaler, blink timing, staging/display and pin outputs.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    blk_d        = blk_q;
    phase_d      = phase_q;
    seg_d        = seg_q;
    dpn_d        = dpn_q;
    dig_d        = dig_q;
    fd_d         = frame_end_s;
    disp_dig_d   = disp_dig_q;
    disp_blank_d = disp_blank_q;
    disp_blink_d = disp_blink_q;
    disp_dp_d    = disp_dp_q;
    disp_lz_d    = disp_lz_q;

    if (tick_s) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      dig_d = '1;
      dig_d[idx_q] = 1'b0;
      if (dark_s) begin
        seg_d = 7'h7F;
        dpn_d = 1'b1;
      end else begin
        seg_d = decode(cur_val_s);
        dpn_d = ~disp_dp_q[idx_q];
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Display takes the staging copy only at frame boundaries, so a frame never tears.
    if (frame_end_s) begin
      disp_dig_d   = stg_dig_q;
      disp_blank_d = stg_blank_q;
      disp_blink_d = stg_blink_q;
      disp_dp_d    = stg_dp_q;
      disp_lz_d    = stg_lz_q;
      if (blk_q == BLK_LAST) begin
        blk_d   = '0;
        phase_d = ~phase_q;
      end else begin
        blk_d = blk_q + 1'b1;
      end
    end else begin
      blk_d = blk_q;
    end

    if (load) begin
      stg_dig_d   = digits;
      stg_blank_d = blank;
      stg_blink_d = blink;
      stg_dp_d    = dp;
      stg_lz_d    = lz_en;
    end else begin
      stg_dig_d   = stg_dig_q;
      stg_blank_d = stg_blank_q;
      stg_blink_d = stg_blink_q;
      stg_dp_d    = stg_dp_q;
      stg_lz_d    = stg_lz_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      blk_q        <= '0;
      phase_q      <= 1'b0;
      stg_dig_q    <= '0;
      stg_blank_q  <= '0;
      stg_blink_q  <= '0;
      stg_dp_q     <= '0;
      stg_lz_q     <= 1'b0;
      disp_dig_q   <= '0;
      disp_blank_q <= '0;
      disp_blink_q <= '0;
      disp_dp_q    <= '0;
      disp_lz_q    <= 1'b0;
      seg_q        <= 7'h7F;
      dpn_q        <= 1'b1;
      dig_q        <= '1;
      fd_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      blk_q        <= blk_d;
      phase_q      <= phase_d;
      stg_dig_q    <= stg_dig_d;
      stg_blank_q  <= stg_blank_d;
      stg_blink_q  <= stg_blink_d;
      stg_dp_q     <= stg_dp_d;
      stg_lz_q     <= stg_lz_d;
      disp_dig_q   <= disp_dig_d;
      disp_blank_q <= disp_blank_d;
      disp_blink_q <= disp_blink_d;
      disp_dp_q    <= disp_dp_d;
      disp_lz_q    <= disp_lz_d;
      seg_q        <= seg_d;
      dpn_q        <= dpn_d;
      dig_q        <= dig_d;
      fd_q         <= fd_d;
    end
  end

  assign seg_n      = seg_q;
  assign dp_n       = dpn_q;
  assign dig_n      = dig_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_fnd_scan.sv
// Directed bench for fnd_scan: two instances (HEX_MODE 1 and 0) with SCAN_DIV=4,
// NUM_DIGITS=4, BLINK_FRAMES=2 sharing the same stimulus.
module tb_fnd_scan;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  blank = 4'h0, blink = 4'h0, dp = 4'h0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg_n, seg_n_h0;
  logic        dp_n, dp_n_h0, frame_done, frame_done_h0;
  logic [3:0]  dig_n, dig_n_h0;

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_a[4], seg_b[4], exp_seg[4];
  logic       dpn_a[4], exp_dpn[4];
  logic [3:0] dig_a[4], dig_b[4];
  logic [3:0] exp_dig[4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  always #5 clk = ~clk;

  fnd_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .load(load), .digits(digits), .blank(blank), .blink(blink),
    .dp(dp), .lz_en(lz_en), .seg_n(seg_n), .dp_n(dp_n), .dig_n(dig_n), .frame_done(frame_done)
  );

  fnd_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(0), .BLINK_FRAMES(2)) dut_h0 (
    .clk(clk), .rst(rst), .load(load), .digits(digits), .blank(blank), .blink(blink),
    .dp(dp), .lz_en(lz_en), .seg_n(seg_n_h0), .dp_n(dp_n_h0), .dig_n(dig_n_h0),
    .frame_done(frame_done_h0)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns at the sample point just after a frame-end edge (frame_done high), bounded.
  task automatic wait_frame_done();
    int n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL frame_done_timeout: frame_done=%b expected 1", frame_done);
    end
  endtask

  // Captures the four digit slots of the frame following the next frame end.
  task automatic read_frame();
    wait_frame_done();
    for (int k = 0; k < 4; k++) begin
      step(4);
      seg_a[k] = seg_n;
      dpn_a[k] = dp_n;
      dig_a[k] = dig_n;
      seg_b[k] = seg_n_h0;
      dig_b[k] = dig_n_h0;
    end
  endtask

  task automatic load_vals(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk,
                           input logic [3:0] p, input logic lz);
    digits = d; blank = bl; blink = bk; dp = p; lz_en = lz;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    checks += 4;
    if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h expected 7f", seg_n); end
    if (dp_n !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b expected 1", dp_n); end
    if (dig_n !== 4'hF) begin errors++; $display("FAIL reset_dig: got %h expected f", dig_n); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
    rst = 1'b0;
    step(3);
    checks++;
    if (dig_n !== 4'hF) begin errors++; $display("FAIL pre_tick_dig: got %h expected f", dig_n); end
    step(1);
    checks += 2;
    if (dig_n !== 4'hE) begin errors++; $display("FAIL first_tick_dig: got %h expected e", dig_n); end
    if (seg_n !== 7'h40) begin errors++; $display("FAIL first_tick_seg: got %h expected 40", seg_n); end
  endtask

  task automatic test_scan();
    load_vals(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
    read_frame();
    exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
    for (int k = 0; k < 4; k++) begin
      checks += 3;
      if (seg_a[k] !== exp_seg[k]) begin errors++; $display("FAIL scan_seg[%0d]: got %h expected %h", k, seg_a[k], exp_seg[k]); end
      if (dig_a[k] !== exp_dig[k]) begin errors++; $display("FAIL scan_dig[%0d]: got %h expected %h", k, dig_a[k], exp_dig[k]); end
      if (dpn_a[k] !== 1'b1) begin errors++; $display("FAIL scan_dp[%0d]: got %b expected 1", k, dpn_a[k]); end
    end
    step(1);
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL fd_pulse_width: got %b expected 0", frame_done); end
  endtask

  // Entered one cycle after a frame end; a load mid-frame must not alter the running frame.
  task automatic test_midframe_load();
    step(3);
    checks += 2;
    if (seg_n !== 7'h19) begin errors++; $display("FAIL mid_d0_seg: got %h expected 19", seg_n); end
    if (dig_n !== 4'hE) begin errors++; $display("FAIL mid_d0_dig: got %h expected e", dig_n); end
    load_vals(16'h5678, 4'h0, 4'h0, 4'h0, 1'b0);
    step(3);
    checks++;
    if (seg_n !== 7'h30) begin errors++; $display("FAIL mid_d1_seg: got %h expected 30", seg_n); end
    step(4);
    checks++;
    if (seg_n !== 7'h24) begin errors++; $display("FAIL mid_d2_seg: got %h expected 24", seg_n); end
    step(4);
    checks += 2;
    if (seg_n !== 7'h79) begin errors++; $display("FAIL mid_d3_seg: got %h expected 79", seg_n); end
    if (frame_done !== 1'b1) begin errors++; $display("FAIL mid_fd: got %b expected 1", frame_done); end
    read_frame();
    exp_seg = '{7'h00, 7'h78, 7'h02, 7'h12};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seg_a[k] !== exp_seg[k]) begin errors++; $display("FAIL new_frame_seg[%0d]: got %h expected %h", k, seg_a[k], exp_seg[k]); end
    end
  endtask

  // Entered at a frame end: load A mid-frame, then load B on the next frame-end edge.
  task automatic test_back_to_back();
    load_vals(16'h2109, 4'h0, 4'h0, 4'h0, 1'b0);
    step(14);
    load_vals(16'h3456, 4'h0, 4'h0, 4'h0, 1'b0);
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_align_fd: got %b expected 1", frame_done); end
    read_frame();
    exp_seg = '{7'h10, 7'h40, 7'h79, 7'h24};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seg_a[k] !== exp_seg[k]) begin errors++; $display("FAIL b2b_first_seg[%0d]: got %h expected %h", k, seg_a[k], exp_seg[k]); end
    end
    read_frame();
    exp_seg = '{7'h02, 7'h12, 7'h19, 7'h30};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seg_a[k] !== exp_seg[k]) begin errors++; $display("FAIL b2b_second_seg[%0d]: got %h expected %h", k, seg_a[k], exp_seg[k]); end
    end
  endtask

  task automatic test_hex();
    load_vals(16'hABCD, 4'h0, 4'h0, 4'h0, 1'b0);
    read_frame();
    exp_seg = '{7'h21, 7'h46, 7'h03, 7'h08};
    for (int k = 0; k < 4; k++) begin
      checks += 3;
      if (seg_a[k] !== exp_seg[k]) begin errors++; $display("FAIL hex1_seg[%0d]: got %h expected %h", k, seg_a[k], exp_seg[k]); end
      if (seg_b[k] !== 7'h7F) begin errors++; $display("FAIL hex0_seg[%0d]: got %h expected 7f", k, seg_b[k]); end
      if (dig_b[k] !== exp_dig[k]) begin errors++; $display("FAIL hex0_dig[%0d]: got %h expected %h", k, dig_b[k], exp_dig[k]); end
    end
  endtask

  task automatic test_lz_blank();
    load_vals(16'h0050, 4'h0, 4'h0, 4'b1100, 1'b1);
    read_frame();
    exp_seg = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    for (int k = 0; k < 4; k++) begin
      checks += 3;
      if (seg_a[k] !== exp_seg[k]) begin errors++; $display("FAIL lz_0050_seg[%0d]: got %h expected %h", k, seg_a[k], exp_seg[k]); end
      if (dpn_a[k] !== 1'b1) begin errors++; $display("FAIL lz_dark_dp[%0d]: got %b expected 1", k, dpn_a[k]); end
      if (dig_a[k] !== exp_dig[k]) begin errors++; $display("FAIL lz_dig[%0d]: got %h expected %h", k, dig_a[k], exp_dig[k]); end
    end
    load_vals(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1);
    read_frame();
    exp_seg = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seg_a[k] !== exp_seg[k]) begin errors++; $display("FAIL lz_zero_seg[%0d]: got %h expected %h", k, seg_a[k], exp_seg[k]); end
    end
    load_vals(16'h1111, 4'b0100, 4'h0, 4'h0, 1'b1);
    read_frame();
    exp_seg = '{7'h79, 7'h79, 7'h7F, 7'h79};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seg_a[k] !== exp_seg[k]) begin errors++; $display("FAIL blank_seg[%0d]: got %h expected %h", k, seg_a[k], exp_seg[k]); end
    end
    digits = 16'h0000; blank = 4'h0; dp = 4'h0; lz_en = 1'b0;
  endtask

  task automatic test_reset_midscan();
    step(5);
    rst = 1'b1;
    #1;
    checks += 4;
    if (seg_n !== 7'h7F) begin errors++; $display("FAIL rst_mid_seg: got %h expected 7f", seg_n); end
    if (dp_n !== 1'b1) begin errors++; $display("FAIL rst_mid_dp: got %b expected 1", dp_n); end
    if (dig_n !== 4'hF) begin errors++; $display("FAIL rst_mid_dig: got %h expected f", dig_n); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_mid_fd: got %b expected 0", frame_done); end
    step(2);
    rst = 1'b0;
    step(3);
    checks++;
    if (dig_n !== 4'hF) begin errors++; $display("FAIL rst_mid_pre_dig: got %h expected f", dig_n); end
    step(1);
    checks += 2;
    if (dig_n !== 4'hE) begin errors++; $display("FAIL rst_mid_tick_dig: got %h expected e", dig_n); end
    if (seg_n !== 7'h40) begin errors++; $display("FAIL rst_mid_tick_seg: got %h expected 40", seg_n); end
  endtask

  // Runs right after test_reset_midscan, so blink timing starts from a known reset point:
  // frame 1 lit, frames 2-3 dark, frame 4 lit for the blinking digit 0.
  task automatic test_blink();
    load_vals(16'h1234, 4'h0, 4'b0001, 4'b0001, 1'b0);
    for (int f = 1; f <= 4; f++) begin
      read_frame();
      if (f == 1 || f == 4) begin
        exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
        exp_dpn = '{1'b0, 1'b1, 1'b1, 1'b1};
      end else begin
        exp_seg = '{7'h7F, 7'h30, 7'h24, 7'h79};
        exp_dpn = '{1'b1, 1'b1, 1'b1, 1'b1};
      end
      for (int k = 0; k < 4; k++) begin
        checks += 2;
        if (seg_a[k] !== exp_seg[k]) begin errors++; $display("FAIL blink_f%0d_seg[%0d]: got %h expected %h", f, k, seg_a[k], exp_seg[k]); end
        if (dpn_a[k] !== exp_dpn[k]) begin errors++; $display("FAIL blink_f%0d_dp[%0d]: got %b expected %b", f, k, dpn_a[k], exp_dpn[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe_load();
    test_back_to_back();
    test_hex();
    test_lz_blank();
    test_reset_midscan();
    test_blink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
